// File: rtl/stack_alu_sequencer_if.sv
// rtl/stack_alu_sequencer_if.sv - instruction token and result stream bundle for stack_alu_sequencer
//
// Signals:
//   in_valid / in_ready / in_opcode / in_data        instruction token stream
//   res_valid / res_ready / res_data / res_overflow  result stream
// Modports:
//   master  token producer / result consumer
//   slave   the sequencer
interface stack_alu_sequencer_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_opcode;
  logic [N-1:0] in_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_overflow;

  modport master (
    output in_valid, in_opcode, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_overflow
  );

  modport slave (
    input  in_valid, in_opcode, in_data, res_ready,
    output in_ready, res_valid, res_data, res_overflow
  );
endinterface

// File: rtl/stack_alu_sequencer.sv
// rtl/stack_alu_sequencer.sv - issue stage that feeds a stack-based ALU one instruction at a time
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (also drives the ALU)
//   bus (slave)                token stream in, result stream out
//   alu_opcode, alu_input_data drive the ALU; opcode is 000 outside the single ISSUE cycle
//   alu_output_data, alu_overflow  ALU result, sampled at the end of the last WAIT cycle
//   depth                      shadow copy of the ALU stack depth
//   err_underflow, err_full    sticky illegal-token flags
//   err_clr                    synchronous clear of the sticky flags (a new error wins)
// Optional feature: define SEQ_ERR_HALT_EN to stop accepting tokens after an error until err_clr.
module stack_alu_sequencer #(
  parameter int N       = 8,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  stack_alu_sequencer_if.slave       bus,
  output logic [2:0]                 alu_opcode,
  output logic [N-1:0]               alu_input_data,
  input  logic [N-1:0]               alu_output_data,
  input  logic                       alu_overflow,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err_underflow,
  output logic                       err_full,
  input  logic                       err_clr
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3
`ifdef SEQ_ERR_HALT_EN
    ,
    S_HALT  = 3'd4
`endif
  } state_t;

  state_t        state, state_d;
  logic [2:0]    op_q;
  logic [N-1:0]  data_q;
  logic [CW-1:0] wait_cnt;
  logic [N-1:0]  res_data_q;
  logic          res_ovf_q;

  logic accept, is_arith, is_push, is_pop;
  logic bad_under, bad_full, tok_err, tok_go, last_wait;

  // Tokens are decoded straight off the bus in IDLE; opcodes 0xx are NOPs.
  assign accept    = (state == S_IDLE) && bus.in_valid;
  assign is_arith  = (bus.in_opcode == OP_ADD) || (bus.in_opcode == OP_MUL);
  assign is_push   = (bus.in_opcode == OP_PUSH);
  assign is_pop    = (bus.in_opcode == OP_POP);
  assign bad_under = accept && ((is_arith && (depth < DW'(2))) || (is_pop && (depth == DW'(0))));
  assign bad_full  = accept && is_push && (depth == DW'(DEPTH));
  assign tok_err   = bad_under || bad_full;
  assign tok_go    = accept && bus.in_opcode[2] && !tok_err;
  assign last_wait = (state == S_WAIT) && (wait_cnt == CW'(ALU_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d        = state;
    bus.in_ready   = 1'b0;
    bus.res_valid  = 1'b0;
    alu_opcode     = OP_NOP;
    alu_input_data = '0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (tok_go) state_d = S_ISSUE;
`ifdef SEQ_ERR_HALT_EN
        else if (tok_err) state_d = S_HALT;
`endif
      end
      S_ISSUE: begin
        alu_opcode     = op_q;
        alu_input_data = data_q;
        state_d        = (op_q == OP_PUSH) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (last_wait) state_d = S_RESP;
      end
      S_RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
`ifdef SEQ_ERR_HALT_EN
      S_HALT: begin
        if (err_clr) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_NOP;
      data_q        <= '0;
      wait_cnt      <= '0;
      res_data_q    <= '0;
      res_ovf_q     <= 1'b0;
      depth         <= '0;
      err_underflow <= 1'b0;
      err_full      <= 1'b0;
    end else begin
      if (tok_go) begin
        op_q   <= bus.in_opcode;
        data_q <= bus.in_data;
      end

      // The ALU applies the stack effect when it samples the opcode, so the
      // shadow depth moves at the same edge.
      if (state == S_ISSUE) begin
        if (op_q == OP_PUSH) depth <= depth + DW'(1);
        else                 depth <= depth - DW'(1);
      end

      if (state == S_ISSUE)                wait_cnt <= '0;
      else if (state == S_WAIT && !last_wait) wait_cnt <= wait_cnt + CW'(1);

      if (last_wait) begin
        res_data_q <= alu_output_data;
        res_ovf_q  <= (op_q != OP_POP) && alu_overflow;
      end

      // Set wins over a simultaneous clear.
      err_underflow <= (err_underflow && !err_clr) || bad_under;
      err_full      <= (err_full && !err_clr) || bad_full;
    end
  end

  assign bus.res_data     = res_data_q;
  assign bus.res_overflow = res_ovf_q;
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb/tb_stack_alu_sequencer.sv - self-checking bench for stack_alu_sequencer with a stack ALU stand-in
module tb_stack_alu_sequencer;
  localparam int N       = 8;
  localparam int DEPTH   = 8;
  localparam int ALU_LAT = 1;
  localparam int DW      = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam int K_NONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_PUSH = 2;
  localparam int K_RES  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_input_data;
  logic [N-1:0]  alu_output_data;
  logic          alu_overflow;
  logic [DW-1:0] depth;
  logic          err_underflow;
  logic          err_full;
  logic          err_clr;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int exp_pulses = 0;

  // Reference model: the stack as a queue of integers plus the two flags.
  int mstk[$];
  bit merr_u = 1'b0;
  bit merr_f = 1'b0;

  // ALU stand-in stack.
  logic [7:0] astk[$];

  stack_alu_sequencer_if #(.N(N)) bus ();

  stack_alu_sequencer #(
    .N(N), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .alu_opcode      (alu_opcode),
    .alu_input_data  (alu_input_data),
    .alu_output_data (alu_output_data),
    .alu_overflow    (alu_overflow),
    .depth           (depth),
    .err_underflow   (err_underflow),
    .err_full        (err_full),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_opcode != 3'b000) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic alu_apply(input logic [2:0] op, input logic [7:0] din);
    logic [7:0] a, b;
    logic [8:0] s;
    logic signed [15:0] p;
    case (op)
      OP_PUSH: astk.push_back(din);
      OP_ADD, OP_MUL: begin
        if (astk.size() >= 2) begin
          b = astk.pop_back();
          a = astk.pop_back();
          if (op == OP_ADD) begin
            s = {a[7], a} + {b[7], b};
            alu_output_data = s[7:0];
            alu_overflow    = s[8] ^ s[7];
          end else begin
            p = $signed(a) * $signed(b);
            alu_output_data = p[7:0];
            alu_overflow    = (p[15:7] != {9{p[7]}});
          end
          astk.push_back(alu_output_data);
        end
      end
      OP_POP: begin
        if (astk.size() >= 1) begin
          alu_output_data = astk.pop_back();
          alu_overflow    = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // ALU stand-in: samples the opcode at the rising edge, result visible shortly after.
  initial begin : alu_stub
    logic [2:0] s_op;
    logic [7:0] s_in;
    alu_output_data = '0;
    alu_overflow    = 1'b0;
    forever begin
      @(posedge clk);
      s_op = alu_opcode;
      s_in = alu_input_data;
      #1;
      if (rst_n) alu_apply(s_op, s_in);
    end
  end

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [7:0] data, input bit clr,
                            output int kind, output int er, output int eo);
    int a, b, r;
    kind = K_NONE; er = 0; eo = 0;
    if (clr) begin merr_u = 1'b0; merr_f = 1'b0; end
    if (op[2] == 1'b0) return;
    if (op == OP_PUSH) begin
      if (mstk.size() == DEPTH) begin merr_f = 1'b1; kind = K_ERR; end
      else begin mstk.push_back(int'(data)); kind = K_PUSH; exp_pulses++; end
    end else if (op == OP_POP) begin
      if (mstk.size() == 0) begin merr_u = 1'b1; kind = K_ERR; end
      else begin er = mstk.pop_back(); eo = 0; kind = K_RES; exp_pulses++; end
    end else begin
      if (mstk.size() < 2) begin merr_u = 1'b1; kind = K_ERR; end
      else begin
        b = sx(mstk.pop_back());
        a = sx(mstk.pop_back());
        r = (op == OP_ADD) ? a + b : a * b;
        eo = (r > 127 || r < -128) ? 1 : 0;
        er = r & 255;
        mstk.push_back(er);
        kind = K_RES;
        exp_pulses++;
      end
    end
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    merr_u = 1'b0;
    merr_f = 1'b0;
    @(negedge clk);
    check("clr_under", err_underflow, 0);
    check("clr_full", err_full, 0);
    check("clr_ready", bus.in_ready, 1);
  endtask

  task automatic send_token(input logic [2:0] op, input logic [7:0] data, input int hold, input bit clr);
    bit ok;
    int kind, er, eo, n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_data   = data;
    err_clr       = clr;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept", ok, 1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      err_clr = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    err_clr = 1'b0;
    model_step(op, data, clr, kind, er, eo);
    @(negedge clk);
    if (kind == K_PUSH) begin
      check("push_op", alu_opcode, OP_PUSH);
      check("push_data", alu_input_data, data);
      check("push_busy", bus.in_ready, 0);
      @(negedge clk);
      check("push_back_idle", bus.in_ready, 1);
    end else if (kind == K_RES) begin
      check("issue_op", alu_opcode, op);
      check("issue_busy", bus.in_ready, 0);
      n = 1;
      while (bus.res_valid !== 1'b1 && n < 10) begin
        @(negedge clk);
        check("wait_busy", bus.in_ready, 0);
        n++;
      end
      check("res_lat", n, ALU_LAT + 2);
      check("res_data", bus.res_data, er);
      check("res_ovf", bus.res_overflow, eo);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", bus.res_valid, 1);
        check("hold_data", bus.res_data, er);
        check("hold_ovf", bus.res_overflow, eo);
        check("hold_busy", bus.in_ready, 0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      check("res_drop", bus.res_valid, 0);
      check("res_idle", bus.in_ready, 1);
    end else begin
      check("no_issue", alu_opcode, 3'b000);
`ifdef SEQ_ERR_HALT_EN
      if (kind == K_ERR) begin
        check("halt_ready", bus.in_ready, 0);
        @(negedge clk);
        check("halt_ready2", bus.in_ready, 0);
        check("halt_no_issue", alu_opcode, 3'b000);
        check("halt_under", err_underflow, merr_u);
        check("halt_full", err_full, merr_f);
        clear_errors();
      end else begin
        check("nop_ready", bus.in_ready, 1);
      end
`else
      check("nop_ready", bus.in_ready, 1);
`endif
    end
    check("depth", depth, mstk.size());
    check("err_under", err_underflow, merr_u);
    check("err_full", err_full, merr_f);
  endtask

  initial begin
    logic [2:0] op;
    int r;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 3'b000;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.in_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_ovf", bus.res_overflow, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_alu_data", alu_input_data, 0);
    check("rst_depth", depth, 0);
    check("rst_err_under", err_underflow, 0);
    check("rst_err_full", err_full, 0);

    // Underflow from reset, then overfill, then clear, then drain.
    send_token(OP_ADD, 8'h00, 0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) send_token(OP_PUSH, 8'(i * 3 + 1), 0, 1'b0);
    check("full_depth", depth, DEPTH);
    clear_errors();
    for (int i = 0; i < DEPTH; i++) send_token(OP_POP, 8'h00, 0, 1'b0);

    send_token(OP_PUSH, 8'd10, 0, 1'b0);
    send_token(OP_PUSH, 8'd20, 0, 1'b0);
    send_token(OP_ADD, 8'h00, 0, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);

    send_token(OP_PUSH, 8'd3, 0, 1'b0);
    send_token(OP_PUSH, 8'd4, 0, 1'b0);
    send_token(OP_MUL, 8'h00, 0, 1'b0);
    send_token(OP_POP, 8'h00, 1, 1'b0);

    send_token(OP_PUSH, 8'h7F, 0, 1'b0);
    send_token(OP_PUSH, 8'h01, 0, 1'b0);
    send_token(OP_ADD, 8'h00, 0, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);

    send_token(OP_PUSH, 8'h80, 0, 1'b0);
    send_token(OP_PUSH, 8'h02, 0, 1'b0);
    send_token(OP_MUL, 8'h00, 5, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);

    // Error and clear in the same cycle: the flag stays set.
    send_token(OP_POP, 8'h00, 0, 1'b1);
    clear_errors();
    send_token(OP_PUSH, 8'd5, 0, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);
    send_token(3'b010, 8'hAA, 0, 1'b0);

    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:          op = {1'b0, 2'($urandom)};
        1, 2, 3, 4: op = OP_PUSH;
        5, 6:       op = OP_ADD;
        7:          op = OP_MUL;
        default:    op = OP_POP;
      endcase
      send_token(op, 8'($urandom), $urandom_range(0, 2), 1'b0);
      if (t % 25 == 24) clear_errors();
    end

    // Reset in the middle of WAIT with a non-zero result already captured.
    while (mstk.size() > 0) send_token(OP_POP, 8'h00, 0, 1'b0);
    send_token(OP_PUSH, 8'd9, 0, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);
    send_token(OP_PUSH, 8'h40, 0, 1'b0);
    send_token(OP_PUSH, 8'h03, 0, 1'b0);
    @(negedge clk);
    check("pre_rst_ready", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_opcode = OP_MUL;
    bus.in_data   = '0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    exp_pulses++;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_res_valid", bus.res_valid, 0);
    check("pre_rst_res_data", bus.res_data, 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    check("mid_rst_res_ovf", bus.res_overflow, 0);
    check("mid_rst_alu_op", alu_opcode, 0);
    check("mid_rst_alu_data", alu_input_data, 0);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_err_under", err_underflow, 0);
    check("mid_rst_err_full", err_full, 0);
    mstk.delete();
    astk.delete();
    merr_u = 1'b0;
    merr_f = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.in_ready, 1);
    send_token(OP_PUSH, 8'd5, 0, 1'b0);
    send_token(OP_POP, 8'h00, 0, 1'b0);

    check("alu_pulses", pulses, exp_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
Upstream issue stage for STACK_BASED_ALU. Accepts an instruction token stream (opcode + operand) over a valid/ready handshake and drives the ALU one instruction at a time. Keeps a shadow stack-depth counter so illegal tokens are rejected before issue. Returns ALU results (ADD/MUL/POP) on a valid/ready result stream with the overflow flag.

Parameters:
N, 8, data width; must equal the ALU's n
DEPTH, 8, ALU stack capacity in entries
ALU_LAT, 1, cycles from the ALU opcode-sample edge to a valid output_data/overflow (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset; also wired to the ALU
in_valid  in  1  instruction token valid
in_ready  out  1  sequencer can accept a token
in_opcode  in  3  100 ADD, 101 MUL, 110 PUSH, 111 POP, 0xx NOP
in_data  in  N  PUSH operand
alu_opcode  out  3  to ALU opcode
alu_input_data  out  N  to ALU input_data
alu_output_data  in  N  from ALU output_data
alu_overflow  in  1  from ALU overflow
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  N  captured result
res_overflow  out  1  captured overflow; 0 for POP
depth  out  $clog2(DEPTH+1)  shadow stack depth
err_underflow  out  1  sticky: ADD/MUL with depth<2, or POP with depth 0
err_full  out  1  sticky: PUSH with depth==DEPTH
err_clr  in  1  synchronous clear of the sticky error flags

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1 once released; alu_opcode=000; alu_input_data=0; res_valid=0; res_data=0; res_overflow=0; depth=0; err flags 0. Reset mid-operation abandons any in-flight instruction and result.
- States: IDLE, ISSUE, WAIT, RESP (HALT only with the optional feature).
- IDLE: in_ready=1. On in_valid&&in_ready, decode the token:
  - NOP: consumed; stay in IDLE; no ALU activity.
  - Illegal token (see error flags): consumed; set the flag; no issue; stay in IDLE.
  - Legal token: latch opcode and data; go to ISSUE.
- ISSUE: exactly one cycle. alu_opcode and alu_input_data carry the latched values. In every other state alu_opcode=000.
  - Depth update at the end of ISSUE: PUSH +1, ADD/MUL -1, POP -1.
  - Next state: PUSH returns to IDLE; other opcodes go to WAIT.
- WAIT: lasts ALU_LAT cycles. At the edge ending the last WAIT cycle, capture res_data<=alu_output_data. res_overflow<=alu_overflow for ADD/MUL, 0 for POP. Go to RESP.
- RESP: res_valid=1; res_data and res_overflow held stable while res_valid && !res_ready. On res_ready, drop res_valid next cycle and go to IDLE.
- Timing (ALU_LAT=1): token accepted at edge T, ISSUE in cycle T+1, WAIT in T+2, res_valid from T+3. PUSH reaches IDLE again at T+2, giving a throughput of one PUSH per 2 cycles.
- Arithmetic is done by the ALU only; the sequencer never modifies data. depth saturates within 0..DEPTH by construction.
- Errors: err_clr and a new error in the same cycle: the flag remains set (set wins). The flags do not block operation.

Optional Feature:
Macro SEQ_ERR_HALT_EN.
- Defined: any error moves the FSM to HALT. In HALT, in_ready=0, nothing is issued, and depth is held. err_clr returns the FSM to IDLE on the next cycle.
- Undefined: there is no HALT state; errors only set the sticky flags and operation continues.

Test Plan:
- PUSH 10, PUSH 20, ADD -> one ALU pulse per token; res_data=30, res_overflow=0; depth 2->1; in_ready low from accept until after the result handshake.
- PUSH 3, PUSH 4, MUL, then POP -> results 12 (ovf 0), then the popped value with res_overflow=0; depth ends at 1 lower.
- PUSH 8'h7F, PUSH 1, ADD -> res_data=8'h80, res_overflow=1.
- From reset: ADD -> err_underflow=1, alu_opcode stays 000, depth=0. DEPTH+1 PUSHes -> err_full=1, depth=DEPTH. err_clr -> both flags 0.
- Hold res_ready=0 for 5 cycles after a MUL of 8'h80*2 -> res_data and res_overflow=1 stable, no new token accepted. Assert rst_n low mid-WAIT -> all outputs at reset values immediately.
- With SEQ_ERR_HALT_EN: POP at depth 0 -> in_ready=0 until err_clr, then accepts PUSH 5 normally.
